demux_route_ctrl: RTL and testbench

- Steering controller directly upstream of the 1-to-2 demultiplexer.
- Accepts a valid/ready word stream tagged with destination and end-of-burst, and buffers it in a small FIFO.
- Drives the demux data line and select, holding select stable for a whole burst.
- Presents per-line valid and honours per-line ready from the B and C consumers.

---
 rtl/demux_route_ctrl.sv | 172 +++++++++++++++++
 tb/tb_demux_route_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: steering controller in front of a 1-to-2 demultiplexer.
// Buffers {dest, last, data} words in a small FIFO and routes them one burst
// at a time. The select is latched from the first word of a burst and held
// until the word marked last is consumed. One idle (bubble) cycle separates
// consecutive bursts.
// Optional build macro: DEMUX_ROUTE_STATS_EN adds per-line pop counters
// cnt_b / cnt_c (16-bit, wrapping).
module demux_route_ctrl #(
    parameter int DATA_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dest,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_select,
    output logic              out_valid_b,
    output logic              out_valid_c,
    input  logic              ready_b,
    input  logic              ready_c,
    output logic              busy
`ifdef DEMUX_ROUTE_STATS_EN
    ,
    output logic [15:0]       cnt_b,
    output logic [15:0]       cnt_c
`endif
);

    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    state_t             state_r;
    state_t             state_next_s;
    logic               select_r;
    logic               select_next_s;

    logic               empty_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;
    logic               head_dest_s;
    logic               head_last_s;
    logic [DATA_W-1:0]  head_data_s;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);

    // No pass-through: a full FIFO refuses input even if it pops this cycle.
    assign in_ready = !full_s && !rst;
    assign push_s   = in_valid && in_ready;

    assign head_s      = mem_r[rd_ptr_r[ADDR_W-1:0]];
    assign head_dest_s = head_s[ENTRY_W-1];
    assign head_last_s = head_s[DATA_W];
    assign head_data_s = head_s[DATA_W-1:0];

    assign out_select = select_r;
    assign busy       = (state_r == ROUTE) || !empty_s;

    // FIFO storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= {in_dest, in_last, in_data};
        end
    end

    // FIFO pointer update on push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Routing state and burst select register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            select_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            select_r <= select_next_s;
        end
    end

    // Next state, select latch, line valids, data drive and pop decision.
    always_comb begin
        state_next_s  = state_r;
        select_next_s = select_r;
        out_valid_b   = 1'b0;
        out_valid_c   = 1'b0;
        out_data      = {DATA_W{1'b0}};
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                // Latch the burst's line from its first word only.
                if (!empty_s) begin
                    select_next_s = head_dest_s;
                    state_next_s  = ROUTE;
                end else begin
                    state_next_s  = IDLE;
                end
            end
            ROUTE: begin
                // Per-word dest is ignored mid-burst; last ends the burst.
                if (!empty_s) begin
                    out_data    = head_data_s;
                    out_valid_b = !select_r;
                    out_valid_c = select_r;
                    pop_s       = select_r ? ready_c : ready_b;
                end else begin
                    pop_s       = 1'b0;
                end
                if (pop_s && head_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ROUTE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

`ifdef DEMUX_ROUTE_STATS_EN
    logic [15:0] cnt_b_r;
    logic [15:0] cnt_c_r;

    assign cnt_b = cnt_b_r;
    assign cnt_c = cnt_c_r;

    // Per-line pop counters, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_b_r <= 16'd0;
            cnt_c_r <= 16'd0;
        end else if (pop_s) begin
            if (select_r) begin
                cnt_c_r <= cnt_c_r + 16'd1;
            end else begin
                cnt_b_r <= cnt_b_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scoreboard bench for demux_route_ctrl: the stimulus side pushes each
// accepted word's expected line/data into a queue; a negedge monitor pops and
// compares on every output handshake and checks that a stalled word holds.
module tb_demux_route_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic       in_dest;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_select;
    logic       out_valid_b;
    logic       out_valid_c;
    logic       ready_b;
    logic       ready_c;
    logic       busy;
`ifdef DEMUX_ROUTE_STATS_EN
    logic [15:0] cnt_b;
    logic [15:0] cnt_c;
    logic [15:0] exp_cnt_b = 16'd0;
    logic [15:0] exp_cnt_c = 16'd0;
`endif

    demux_route_ctrl #(.DATA_W(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_select(out_select),
        .out_valid_b(out_valid_b), .out_valid_c(out_valid_c),
        .ready_b(ready_b), .ready_c(ready_c), .busy(busy)
`ifdef DEMUX_ROUTE_STATS_EN
        , .cnt_b(cnt_b), .cnt_c(cnt_c)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst goes to the line named by its first word.
    typedef struct {
        logic       line;
        logic [1:0] data;
    } exp_t;
    exp_t exp_q[$];
    bit   in_burst   = 1'b0;
    bit   burst_line = 1'b0;

    function automatic void model_push(input logic [1:0] d, input logic dest, input logic last);
        exp_t e;
        if (!in_burst) begin
            burst_line = dest;
            in_burst   = 1'b1;
        end
        e.line = burst_line;
        e.data = d;
        exp_q.push_back(e);
        if (last) in_burst = 1'b0;
    endfunction

    function automatic void model_flush();
        exp_q.delete();
        in_burst = 1'b0;
    endfunction

    // Monitor state
    int   cyc = 0;
    int   fire_cyc[$];
    bit   fire_sel[$];
    logic prev_valid = 1'b0;
    logic prev_fire  = 1'b0;
    logic prev_sel   = 1'b0;
    logic [1:0] prev_data = 2'b00;
    logic fb, fc;
    exp_t e_mon;

    // Output monitor: handshake scoreboard plus hold-while-stalled check.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_valid = 1'b0;
            prev_fire  = 1'b0;
        end else begin
            if (prev_valid && !prev_fire)
                chk("hold_stable", {out_valid_c, out_valid_b, out_select, out_data},
                    {prev_sel, ~prev_sel, prev_sel, prev_data});
            fb = out_valid_b && ready_b;
            fc = out_valid_c && ready_c;
            if (fb || fc) begin
                fire_cyc.push_back(cyc);
                fire_sel.push_back(fc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got data %0h sel %0b expected no word", out_data, out_select);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("route", {out_valid_c, out_valid_b, out_select, out_data},
                        {e_mon.line, ~e_mon.line, e_mon.line, e_mon.data});
`ifdef DEMUX_ROUTE_STATS_EN
                    if (e_mon.line) exp_cnt_c = exp_cnt_c + 16'd1;
                    else            exp_cnt_b = exp_cnt_b + 16'd1;
`endif
                end
            end
            prev_valid = out_valid_b || out_valid_c;
            prev_fire  = fb || fc;
            prev_sel   = out_select;
            prev_data  = out_data;
        end
    end

    // Random consumer readiness, changed just after each rising edge.
    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready_b = 1'($urandom);
            ready_c = 1'($urandom);
        end
    end

    int last_push_cyc = 0;

    task automatic send(input logic [1:0] d, input logic dest, input logic last);
        int g = 0;
        bit done = 1'b0;
        @(negedge clk);
        in_data = d; in_dest = dest; in_last = last; in_valid = 1'b1;
        while (!done) begin
            if (in_ready) begin
                @(posedge clk);
                model_push(d, dest, last);
                last_push_cyc = cyc + 1;
                done = 1'b1;
            end else begin
                g++;
                if (g > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_fires(input int n);
        int g = 0;
        while (fire_cyc.size() < n && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        chk("fires_seen", (fire_cyc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk); #1;
            g++;
        end
        chk(name, exp_q.size(), 0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk({name, "_busy"}, busy, 1'b0);
    endtask

    int n0;
    int p;
    int offs[5] = '{0, 1, 2, 4, 5};
    bit sels[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 2'b11; in_dest = 1'b1; in_last = 1'b1;
        ready_b = 1'b1; ready_c = 1'b1;

        // Reset with in_valid high
        @(negedge clk); @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_outputs", {out_valid_b, out_valid_c, out_select, out_data, busy}, 6'd0);
        in_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // Single-word burst latency
        ready_b = 1'b0; ready_c = 1'b1;
        n0 = fire_cyc.size();
        send(2'b10, 1'b1, 1'b1);
        p = last_push_cyc;
        wait_fires(n0 + 1);
        if (fire_cyc.size() > n0) begin
            chk("single_latency", fire_cyc[n0], p + 1);
            chk("single_line", fire_sel[n0], 1'b1);
        end
        @(negedge clk); #1;
        chk("single_idle_busy", busy, 1'b0);

        // Back-to-back bursts with one bubble
        ready_b = 1'b1; ready_c = 1'b1;
        n0 = fire_cyc.size();
        send(2'd1, 1'b0, 1'b0);
        send(2'd2, 1'b0, 1'b0);
        send(2'd3, 1'b0, 1'b1);
        send(2'd0, 1'b1, 1'b0);
        send(2'd1, 1'b1, 1'b1);
        wait_fires(n0 + 5);
        if (fire_cyc.size() >= n0 + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("b2b_timing", fire_cyc[n0 + k] - fire_cyc[n0], offs[k]);
                chk("b2b_line", fire_sel[n0 + k], sels[k]);
            end
        end
        drain("b2b_drain");

        // FIFO full: 5th word held until the first pop
        ready_b = 1'b0; ready_c = 1'b0;
        n0 = fire_cyc.size();
        for (int i = 0; i < 4; i++) send(2'(i), 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("full_in_ready", in_ready, 1'b0);
        fork
            send(2'b11, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("full_hold_ready", in_ready, 1'b0);
                end
                @(posedge clk); #1 ready_b = 1'b1;
            end
        join
        drain("full_drain");
        chk("full_count", fire_cyc.size() - n0, 5);

        // Backpressure on B with ready_c high, mid-burst word tagged C
        ready_b = 1'b0; ready_c = 1'b1;
        n0 = fire_cyc.size();
        send(2'd1, 1'b0, 1'b0);
        send(2'd2, 1'b1, 1'b0);
        send(2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1 ready_b = (i % 3 != 1);
            @(negedge clk); #1;
            if (out_valid_b && !ready_b)
                chk("bp_no_pop_on_c", out_valid_c, 1'b0);
        end
        drain("bp_drain");
        if (fire_cyc.size() >= n0 + 3)
            for (int k = 0; k < 3; k++) chk("bp_line_b", fire_sel[n0 + k], 1'b0);

        // Randomized traffic with random consumer readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++)
            send(2'($urandom), 1'($urandom), (i == 59) || ($urandom_range(0, 3) == 0));
        drain("rand_drain");
        rand_ready = 1'b0;
        @(posedge clk); #2;
`ifdef DEMUX_ROUTE_STATS_EN
        chk("stats_b", cnt_b, exp_cnt_b);
        chk("stats_c", cnt_c, exp_cnt_c);
`endif

        // Reset mid-burst after 2 of 4 words
        ready_b = 1'b0; ready_c = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 1'b0, i == 3);
        n0 = fire_cyc.size();
        @(posedge clk); #1 ready_b = 1'b1;
        wait_fires(n0 + 2);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {out_valid_b, out_valid_c, out_select, out_data, busy, in_ready}, 7'd0);
        model_flush();
`ifdef DEMUX_ROUTE_STATS_EN
        chk("midrst_cnt_b", cnt_b, 16'd0);
        exp_cnt_b = 16'd0;
        exp_cnt_c = 16'd0;
`endif
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_empty", {busy, in_ready, out_valid_b}, 3'b010);
        ready_c = 1'b1;
        send(2'd3, 1'b1, 1'b1);
        drain("recover_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
